// File: rtl/hdlc_pkg.sv
// hdlc_pkg
// Shared definitions for the HDLC transmit sequencer and the frame check
// sequence generator.
//   - txState_t and the S_* constants: sequencer state encoding
//   - FLAG / ABORT: the fixed 8-bit line patterns (sent LSB first)
//   - FCS_POLY: CRC-16 generator polynomial x^16+x^15+x^2+1
//   - fcsStep(): one bit-serial CRC update, shared by Tx and Rx checkers

package hdlc_pkg;

    // Sequencer states, kept as plain sized constants so older code that
    // compares against raw 3-bit values keeps working.
    typedef logic [2:0] txState_t;

    localparam txState_t S_IDLE   = 3'd0;
    localparam txState_t S_FLAG_S = 3'd1;
    localparam txState_t S_DATA   = 3'd2;
    localparam txState_t S_FCS    = 3'd3;
    localparam txState_t S_FLAG_E = 3'd4;
    localparam txState_t S_ABORT  = 3'd5;

    localparam logic [7:0]  FLAG     = 8'h7E;
    localparam logic [7:0]  ABORT    = 8'hFE;
    localparam logic [15:0] FCS_POLY = 16'h8005;

    // One CRC step: the incoming bit is compared with the register MSB and,
    // when they differ, the polynomial is folded into the shifted value.
    function automatic logic [15:0] fcsStep(input logic [15:0] crc, input logic bitIn);
        logic feedback;
        feedback = crc[15] ^ bitIn;
        fcsStep  = {crc[14:0], 1'b0} ^ (feedback ? FCS_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/hdlc_fcs16.sv
// hdlc_fcs16
// Bit-serial CRC-16 (polynomial 0x8005, initial value 0, no final XOR).
// The same block is used by the receive-side checker.
// Ports:
//   Clk     in   system clock, rising edge
//   Rst     in   synchronous active-high reset, clears the CRC
//   Clear   in   synchronous clear at the start of a new frame
//   Enable  in   fold DataBit into the CRC on this edge
//   DataBit in   payload bit, in line order
//   Crc     out  current CRC register value

module hdlc_fcs16
    import hdlc_pkg::*;
(
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Clear,
    input  logic        Enable,
    input  logic        DataBit,
    output logic [15:0] Crc
);

    // CRC register: cleared by reset or a frame start, otherwise advanced one
    // bit whenever the owner presents a payload bit.
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            Crc <= 16'h0000;
        end else if (Enable) begin
            Crc <= fcsStep(Crc, DataBit);
        end
    end

endmodule

// File: rtl/hdlc_tx_sequencer.sv
// hdlc_tx_sequencer
// Bit-serial HDLC transmitter: start flag, payload bytes from the Tx buffer,
// 16-bit FCS, end flag, with zero insertion over payload and FCS. Drives idle
// ones between frames and can replace a frame in progress with the abort
// pattern.
// Parameters:
//   MAX_BYTES        largest accepted frame size in bytes
// Ports:
//   Clk              system clock, rising edge
//   Rst              synchronous active-high reset
//   Tx_Enable        start-frame request, sampled in IDLE only
//   Tx_AbortFrame    abort request, sampled while a frame is in progress
//   Tx_FrameSize     payload byte count, sampled with Tx_Enable
//   Tx_Data          buffer read data, valid the cycle after Tx_RdBuff
//   Tx_RdBuff        one-cycle pulse popping the next buffer byte
//   Tx               serial line, LSB first, idle level 1
//   Tx_ValidFrame    high while Tx carries a frame bit (flags included)
//   Tx_Done          high in IDLE
//   Tx_AbortedTrans  sticky abort indication, cleared on the next accepted frame

module hdlc_tx_sequencer
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES = 126
)
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_FrameSize,
    input  logic [7:0] Tx_Data,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans
);

    localparam logic [7:0] MaxSize = 8'(MAX_BYTES);

    // Position registers describe the bit currently on Tx. During an inserted
    // zero they keep pointing at the last real bit, which is what stalls the
    // bit index, CRC and buffer-read schedule.
    txState_t    state;
    logic [2:0]  bitIdx;
    logic [7:0]  byteCnt;
    logic [7:0]  frameSize;
    logic [7:0]  curByte;
    logic [7:0]  holdByte;
    logic [2:0]  onesCnt;
    logic        rdPending;
    logic [15:0] crc;

    txState_t    nState;
    logic [2:0]  nIdx;
    logic [7:0]  nByteCnt;
    logic [2:0]  nOnes;
    logic        nTx;
    logic        nValid;
    logic        nDone;
    logic        nRd;
    logic        txBit;
    logic        loadHold;
    logic        crcEn;
    logic        crcClr;
    logic        acceptFrame;
    logic        abortTaken;
    logic        lastByte;
    logic        sizeOk;
    logic        inFrame;
    logic [3:0]  fcsPos;
    logic [3:0]  nFcsPos;

    assign lastByte = (byteCnt == frameSize - 8'd1);
    assign sizeOk   = (Tx_FrameSize != 8'd0) && (Tx_FrameSize <= MaxSize);
    assign inFrame  = (state == S_FLAG_S) || (state == S_DATA) ||
                      (state == S_FCS)    || (state == S_FLAG_E);
    // In FCS the byte counter only distinguishes the low and high CRC byte.
    assign fcsPos   = {byteCnt[0], bitIdx};

    // The CRC is advanced on the edge that loads a payload bit into Tx, so by
    // the time the last payload bit is on the line the register already holds
    // the final FCS and can be sent directly.
    hdlc_fcs16 fcsGen (
        .Clk     (Clk),
        .Rst     (Rst),
        .Clear   (crcClr),
        .Enable  (crcEn),
        .DataBit (txBit),
        .Crc     (crc)
    );

    // Next-bit selection. An abort outranks everything while a frame is in
    // progress. In DATA/FCS a run of five ones forces an inserted zero before
    // the position is allowed to advance; otherwise the position steps to the
    // next real bit and the ones counter follows the bit being sent.
    always_comb begin
        nState      = state;
        nIdx        = bitIdx;
        nByteCnt    = byteCnt;
        nOnes       = onesCnt;
        nTx         = 1'b1;
        nValid      = 1'b0;
        nDone       = 1'b0;
        nRd         = 1'b0;
        txBit       = 1'b0;
        loadHold    = 1'b0;
        crcEn       = 1'b0;
        crcClr      = 1'b0;
        acceptFrame = 1'b0;
        abortTaken  = 1'b0;
        nFcsPos     = 4'd0;

        if (inFrame && Tx_AbortFrame) begin
            abortTaken = 1'b1;
            nState     = S_ABORT;
            nIdx       = 3'd0;
            nTx        = ABORT[0];
        end else begin
            case (state)
                S_IDLE: begin
                    if (Tx_Enable && sizeOk) begin
                        acceptFrame = 1'b1;
                        crcClr      = 1'b1;
                        nState      = S_FLAG_S;
                        nIdx        = 3'd0;
                        nByteCnt    = 8'd0;
                        nOnes       = 3'd0;
                        nTx         = FLAG[0];
                        nValid      = 1'b1;
                    end else begin
                        nDone = 1'b1;
                    end
                end

                S_FLAG_S: begin
                    nValid = 1'b1;
                    if (bitIdx != 3'd7) begin
                        nIdx = bitIdx + 3'd1;
                        nTx  = FLAG[nIdx];
                        nRd  = (nIdx == 3'd5);
                    end else begin
                        nState   = S_DATA;
                        nIdx     = 3'd0;
                        nByteCnt = 8'd0;
                        loadHold = 1'b1;
                        txBit    = holdByte[0];
                        crcEn    = 1'b1;
                        nTx      = txBit;
                        nOnes    = txBit ? onesCnt + 3'd1 : 3'd0;
                    end
                end

                S_DATA: begin
                    nValid = 1'b1;
                    if (onesCnt == 3'd5) begin
                        nTx   = 1'b0;
                        nOnes = 3'd0;
                    end else begin
                        if (bitIdx != 3'd7) begin
                            nIdx  = bitIdx + 3'd1;
                            txBit = curByte[nIdx];
                            crcEn = 1'b1;
                            nRd   = (nIdx == 3'd5) && !lastByte;
                        end else if (!lastByte) begin
                            nIdx     = 3'd0;
                            nByteCnt = byteCnt + 8'd1;
                            loadHold = 1'b1;
                            txBit    = holdByte[0];
                            crcEn    = 1'b1;
                        end else begin
                            nState   = S_FCS;
                            nIdx     = 3'd0;
                            nByteCnt = 8'd0;
                            txBit    = crc[0];
                        end
                        nTx   = txBit;
                        nOnes = txBit ? onesCnt + 3'd1 : 3'd0;
                    end
                end

                S_FCS: begin
                    nValid = 1'b1;
                    if (onesCnt == 3'd5) begin
                        nTx   = 1'b0;
                        nOnes = 3'd0;
                    end else if (fcsPos != 4'd15) begin
                        nFcsPos  = fcsPos + 4'd1;
                        nIdx     = nFcsPos[2:0];
                        nByteCnt = {7'd0, nFcsPos[3]};
                        txBit    = crc[nFcsPos];
                        nTx      = txBit;
                        nOnes    = txBit ? onesCnt + 3'd1 : 3'd0;
                    end else begin
                        nState = S_FLAG_E;
                        nIdx   = 3'd0;
                        nTx    = FLAG[0];
                        nOnes  = 3'd0;
                    end
                end

                S_FLAG_E: begin
                    if (bitIdx != 3'd7) begin
                        nValid = 1'b1;
                        nIdx   = bitIdx + 3'd1;
                        nTx    = FLAG[nIdx];
                    end else begin
                        nState = S_IDLE;
                        nIdx   = 3'd0;
                        nDone  = 1'b1;
                    end
                end

                S_ABORT: begin
                    if (bitIdx != 3'd7) begin
                        nIdx = bitIdx + 3'd1;
                        nTx  = ABORT[nIdx];
                    end else begin
                        nState = S_IDLE;
                        nIdx   = 3'd0;
                        nDone  = 1'b1;
                    end
                end

                default: begin
                    nState = S_IDLE;
                    nIdx   = 3'd0;
                    nDone  = 1'b1;
                end
            endcase
        end
    end

    // State and registered outputs. The buffer byte is captured one cycle
    // after the read pulse into a holding register and only moved into the
    // transmit byte at the byte boundary, so stuffing delays never lose it.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state           <= S_IDLE;
            bitIdx          <= 3'd0;
            byteCnt         <= 8'd0;
            frameSize       <= 8'd0;
            curByte         <= 8'd0;
            holdByte        <= 8'd0;
            onesCnt         <= 3'd0;
            rdPending       <= 1'b0;
            Tx              <= 1'b1;
            Tx_ValidFrame   <= 1'b0;
            Tx_RdBuff       <= 1'b0;
            Tx_Done         <= 1'b1;
            Tx_AbortedTrans <= 1'b0;
        end else begin
            state         <= nState;
            bitIdx        <= nIdx;
            byteCnt       <= nByteCnt;
            onesCnt       <= nOnes;
            Tx            <= nTx;
            Tx_ValidFrame <= nValid;
            Tx_RdBuff     <= nRd;
            Tx_Done       <= nDone;
            rdPending     <= Tx_RdBuff;
            if (rdPending) begin
                holdByte <= Tx_Data;
            end
            if (loadHold) begin
                curByte <= holdByte;
            end
            if (acceptFrame) begin
                frameSize       <= Tx_FrameSize;
                Tx_AbortedTrans <= 1'b0;
            end else if (abortTaken) begin
                Tx_AbortedTrans <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hdlc_tx_sequencer.sv
// tb_hdlc_tx_sequencer
// Self-checking bench for hdlc_tx_sequencer. Each frame's expected line
// sequence is built from the protocol rules (flags, LSB-first payload, CRC-16
// 0x8005 over the payload, zero insertion after five ones) and compared cycle
// by cycle against Tx, Tx_ValidFrame, Tx_Done, Tx_RdBuff and Tx_AbortedTrans.

module tb_hdlc_tx_sequencer;

    logic       Clk;
    logic       Rst;
    logic       Tx_Enable;
    logic       Tx_AbortFrame;
    logic [7:0] Tx_FrameSize;
    logic [7:0] Tx_Data;
    logic       Tx_RdBuff;
    logic       Tx;
    logic       Tx_ValidFrame;
    logic       Tx_Done;
    logic       Tx_AbortedTrans;

    int total = 0;
    int bad   = 0;

    logic [7:0] frameData [0:255];
    int         rdPtr;
    logic       prevRd;

    hdlc_tx_sequencer #(.MAX_BYTES(126)) dut (
        .Clk             (Clk),
        .Rst             (Rst),
        .Tx_Enable       (Tx_Enable),
        .Tx_AbortFrame   (Tx_AbortFrame),
        .Tx_FrameSize    (Tx_FrameSize),
        .Tx_Data         (Tx_Data),
        .Tx_RdBuff       (Tx_RdBuff),
        .Tx              (Tx),
        .Tx_ValidFrame   (Tx_ValidFrame),
        .Tx_Done         (Tx_Done),
        .Tx_AbortedTrans (Tx_AbortedTrans)
    );

    // Free-running clock, 10 time units per cycle
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge. The buffer answers a
    // read pulse seen in the previous cycle; otherwise Tx_Data carries junk.
    task automatic nextCycle();
        @(posedge Clk);
        #1;
        if (prevRd) begin
            Tx_Data = (rdPtr < 256) ? frameData[rdPtr] : 8'h00;
            rdPtr++;
        end else begin
            Tx_Data = 8'($urandom);
        end
        prevRd = Tx_RdBuff;
    endtask

    task automatic checkIdle(input string tag, input logic expAborted);
        checkOutput({tag, " tx"},      16'(Tx),              16'd1);
        checkOutput({tag, " valid"},   16'(Tx_ValidFrame),   16'd0);
        checkOutput({tag, " rdbuff"},  16'(Tx_RdBuff),       16'd0);
        checkOutput({tag, " done"},    16'(Tx_Done),         16'd1);
        checkOutput({tag, " aborted"}, 16'(Tx_AbortedTrans), 16'(expAborted));
    endtask

    // Sends one frame of frameData[0..size-1], starting in the current (idle)
    // cycle. abortByte >= 0 pulses Tx_AbortFrame at a random bit of that
    // payload byte; resetAt > 0 pulses Rst in that frame cycle instead.
    task automatic applyStimulus(input int size, input int abortByte, input int resetAt, input bit abortWithEnable);
        bit          expBits[$];
        bit          expRd[$];
        int          expPos[$];
        logic [7:0]  flagByte;
        logic [15:0] crcVal;
        bit          b;
        bit          fb;
        int          ones;
        int          len;
        int          abortAt;
        int          target;
        int          rdCount;

        flagByte = 8'h7E;
        for (int i = 0; i < 8; i++) begin
            expBits.push_back(flagByte[i]);
            expRd.push_back(i == 5);
            expPos.push_back(-1);
        end
        crcVal = 16'h0000;
        ones   = 0;
        for (int i = 0; i < size * 8 + 16; i++) begin
            if (i < size * 8) begin
                b      = frameData[i / 8][i % 8];
                fb     = crcVal[15] ^ b;
                crcVal = {crcVal[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
                expRd.push_back((i % 8 == 5) && (i / 8 < size - 1));
                expPos.push_back(i);
            end else begin
                b = crcVal[i - size * 8];
                expRd.push_back(1'b0);
                expPos.push_back(-1);
            end
            expBits.push_back(b);
            ones = b ? ones + 1 : 0;
            if (ones == 5) begin
                expBits.push_back(1'b0);
                expRd.push_back(1'b0);
                expPos.push_back(-2);
                ones = 0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            expBits.push_back(flagByte[i]);
            expRd.push_back(1'b0);
            expPos.push_back(-1);
        end

        abortAt = -1;
        if (abortByte >= 0) begin
            target = abortByte * 8 + int'($urandom_range(0, 7));
            for (int i = 0; i < expPos.size(); i++) begin
                if (expPos[i] == target) abortAt = i + 1;
            end
        end

        rdPtr         = 0;
        rdCount       = 0;
        len           = expBits.size();
        Tx_FrameSize  = 8'(size);
        Tx_Enable     = 1'b1;
        Tx_AbortFrame = abortWithEnable;

        for (int c = 1; c <= len; c++) begin
            nextCycle();
            Tx_Enable     = 1'($urandom_range(0, 1));
            Tx_FrameSize  = 8'($urandom);
            Tx_AbortFrame = 1'b0;
            checkOutput($sformatf("tx n%0d c%0d", size, c),      16'(Tx),              16'(expBits[c-1]));
            checkOutput($sformatf("valid n%0d c%0d", size, c),   16'(Tx_ValidFrame),   16'd1);
            checkOutput($sformatf("done n%0d c%0d", size, c),    16'(Tx_Done),         16'd0);
            checkOutput($sformatf("rdbuff n%0d c%0d", size, c),  16'(Tx_RdBuff),       16'(expRd[c-1]));
            checkOutput($sformatf("aborted n%0d c%0d", size, c), 16'(Tx_AbortedTrans), 16'd0);
            if (Tx_RdBuff) rdCount++;

            if (c == resetAt) begin
                Rst       = 1'b1;
                Tx_Enable = 1'b0;
                nextCycle();
                Rst = 1'b0;
                checkIdle("after reset", 1'b0);
                return;
            end

            if (c == abortAt) begin
                Tx_AbortFrame = 1'b1;
                for (int j = 1; j <= 8; j++) begin
                    nextCycle();
                    Tx_AbortFrame = 1'($urandom_range(0, 1));
                    Tx_Enable     = 1'($urandom_range(0, 1));
                    checkOutput($sformatf("abort tx b%0d", j),      16'(Tx),              (j == 1) ? 16'd0 : 16'd1);
                    checkOutput($sformatf("abort valid b%0d", j),   16'(Tx_ValidFrame),   16'd0);
                    checkOutput($sformatf("abort rdbuff b%0d", j),  16'(Tx_RdBuff),       16'd0);
                    checkOutput($sformatf("abort done b%0d", j),    16'(Tx_Done),         16'd0);
                    checkOutput($sformatf("abort flag b%0d", j),    16'(Tx_AbortedTrans), 16'd1);
                end
                nextCycle();
                Tx_Enable     = 1'b0;
                Tx_AbortFrame = 1'b0;
                checkIdle("after abort", 1'b1);
                return;
            end
        end

        nextCycle();
        Tx_Enable     = 1'b0;
        Tx_AbortFrame = 1'($urandom_range(0, 1));
        checkIdle($sformatf("frame end n%0d", size), 1'b0);
        checkOutput($sformatf("rd count n%0d", size), 16'(rdCount), 16'(size));
    endtask

    initial begin
        Rst           = 1'b1;
        Tx_Enable     = 1'b0;
        Tx_AbortFrame = 1'b0;
        Tx_FrameSize  = 8'd0;
        Tx_Data       = 8'd0;
        prevRd        = 1'b0;
        rdPtr         = 0;

        repeat (2) @(posedge Clk);
        #1;
        checkIdle("reset", 1'b0);
        Rst           = 1'b0;
        Tx_AbortFrame = 1'b1;
        nextCycle();
        Tx_AbortFrame = 1'b0;
        checkIdle("idle abort ignored", 1'b0);

        $display("[TB] single zero byte");
        frameData[0] = 8'h00;
        applyStimulus(1, -1, -1, 1'b0);

        $display("[TB] two 0xFF bytes");
        frameData[0] = 8'hFF;
        frameData[1] = 8'hFF;
        applyStimulus(2, -1, -1, 1'b0);

        $display("[TB] maximum size random frame");
        for (int i = 0; i < 126; i++) frameData[i] = 8'($urandom);
        applyStimulus(126, -1, -1, 1'b0);

        $display("[TB] abort in third byte of ten");
        for (int i = 0; i < 10; i++) frameData[i] = 8'($urandom);
        applyStimulus(10, 2, -1, 1'b0);

        $display("[TB] out of range sizes");
        Tx_Enable    = 1'b1;
        Tx_FrameSize = 8'd0;
        nextCycle();
        Tx_Enable = 1'b0;
        checkIdle("size0 c1", 1'b1);
        nextCycle();
        checkIdle("size0 c2", 1'b1);
        Tx_Enable    = 1'b1;
        Tx_FrameSize = 8'd127;
        nextCycle();
        Tx_Enable = 1'b0;
        checkIdle("size127 c1", 1'b1);
        nextCycle();
        checkIdle("size127 c2", 1'b1);

        $display("[TB] reset during payload");
        for (int i = 0; i < 5; i++) frameData[i] = 8'($urandom);
        applyStimulus(5, -1, 20, 1'b0);
        for (int i = 0; i < 4; i++) frameData[i] = 8'($urandom);
        applyStimulus(4, -1, -1, 1'b0);

        $display("[TB] random back-to-back frames");
        for (int f = 0; f < 4; f++) begin
            int sz;
            sz = int'($urandom_range(1, 12));
            for (int i = 0; i < sz; i++) frameData[i] = 8'($urandom);
            applyStimulus(sz, -1, -1, (f == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
